// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: byte FIFO with valid/ack drain, sticky overrun, and an optional
// burst/idle gap timer that pulses timeout. The gap timer is built only with UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned TIMEOUT = 160
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [7:0]    rx_data,
    input  logic          rx_ready,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ack,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          ovr_clr,
    output logic          timeout
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          strobe, full, push, pop, drop;

    assign strobe  = rx_ready & enable;
    assign full    = (count_q == FullCount);
    assign m_valid = (count_q != '0);
    assign pop     = m_valid & m_ack;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push    = strobe & (~full | pop);
    assign drop    = strobe & full & ~pop;

    assign m_data  = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign overrun = overrun_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overrun_d = overrun_q;
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= rx_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam logic       StIdle  = 1'b0;
    localparam logic       StBurst = 1'b1;
    // Last gap value before the pulse; the pulse then lands TIMEOUT cycles after the last strobe.
    localparam logic [15:0] GapLast = 16'(TIMEOUT - 2);

    logic        state_q, state_d;
    logic [15:0] gap_q, gap_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            gap_d   = '0;
        end else if (rx_ready) begin
            state_d = StBurst;
            gap_d   = '0;
        end else if (state_q == StBurst) begin
            if (gap_q == GapLast) begin
                timeout_d = 1'b1;
                state_d   = StIdle;
                gap_d     = '0;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gap_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl; timeout checks follow UART_RX_TIMEOUT_EN.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned AW      = 3;
    localparam int unsigned TIMEOUT = 160;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ack = 1'b0;
    logic [AW:0] count;
    logic        overrun;
    logic        ovr_clr = 1'b0;
    logic        timeout;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          t_pulses = 0;
    int          t_cycle = 0;
    int          n0;
    int          n1;
    logic [7:0]  exp_q[$];

    uart_rx_ctrl #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ack    (m_ack),
        .count    (count),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pops and timeout pulses are observed mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ack) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", {31'd0, m_valid}, 32'd0);
            end else begin
                check("pop_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (!rst && timeout) begin
            t_pulses++;
            t_cycle = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        logic acc;
        acc = enable && ((exp_q.size() < DEPTH) || (m_ack && exp_q.size() > 0));
        rx_data  = d;
        rx_ready = 1'b1;
        if (acc) exp_q.push_back(d);
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_ack = 1'b1;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        m_ack = 1'b0;
        if (n >= 40) check("drain_bound", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_quiet_pulses(input string tag, input int from_cycle);
        t_pulses = 0;
        repeat (200) tick();
        check(tag, 32'(t_pulses), 32'd0);
        if (cyc < from_cycle) check("cycle_order", 32'(cyc), 32'(from_cycle));
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_data", {24'd0, m_data}, 32'd0);

        // Basic buffering then back-to-back delivery.
        strobe(8'h41);
        strobe(8'h42);
        strobe(8'h43);
        check("three_count", {28'd0, count}, 32'd3);
        check("three_head", {24'd0, m_data}, 32'h41);
        m_ack = 1'b1;
        repeat (3) tick();
        m_ack = 1'b0;
        check("three_empty_valid", {31'd0, m_valid}, 32'd0);
        check("three_empty_count", {28'd0, count}, 32'd0);

        // Overrun on a full FIFO with no ack.
        for (int i = 0; i < 8; i++) strobe(8'(i));
        check("full_count", {28'd0, count}, 32'd8);
        strobe(8'hFF);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("ovr_count", {28'd0, count}, 32'd8);
        drain();
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        // Full FIFO with push and pop in the same cycle.
        for (int i = 0; i < 8; i++) strobe(8'h10 + 8'(i));
        m_ack = 1'b1;
        strobe(8'h55);
        m_ack = 1'b0;
        check("pushpop_ovr", {31'd0, overrun}, 32'd0);
        check("pushpop_count", {28'd0, count}, 32'd8);
        drain();
        check("pushpop_drained", {28'd0, count}, 32'd0);

        // Gap timer: one strobe, then a strobe restarting the gap.
        repeat (200) tick();
        t_pulses = 0;
        n0 = cyc;
        strobe(8'hA0);
        repeat (200) tick();
`ifdef UART_RX_TIMEOUT_EN
        check("tmo_single_pulses", 32'(t_pulses), 32'd1);
        check("tmo_single_cycle", 32'(t_cycle), 32'(n0 + int'(TIMEOUT)));
`else
        check("tmo_off_pulses", 32'(t_pulses), 32'd0);
`endif
        t_pulses = 0;
        strobe(8'hA1);
        repeat (99) tick();
        n1 = cyc;
        strobe(8'hA2);
        repeat (200) tick();
`ifdef UART_RX_TIMEOUT_EN
        check("tmo_restart_pulses", 32'(t_pulses), 32'd1);
        check("tmo_restart_cycle", 32'(t_cycle), 32'(n1 + int'(TIMEOUT)));
`else
        check("tmo_off_restart", 32'(t_pulses), 32'd0);
`endif
        drain();

        // Enable low: strobes ignored, burst aborted without a pulse, drain still works.
        enable = 1'b0;
        strobe(8'h33);
        check("dis_count", {28'd0, count}, 32'd0);
        check("dis_valid", {31'd0, m_valid}, 32'd0);
        check_quiet_pulses("dis_no_pulse", n1);
        enable = 1'b1;
        strobe(8'h34);
        repeat (20) tick();
        enable = 1'b0;
        check_quiet_pulses("dis_burst_no_pulse", n1);
        check("dis_hold_count", {28'd0, count}, 32'd1);
        drain();
        check("dis_drained", {28'd0, count}, 32'd0);
        enable = 1'b1;

        // Reset mid-operation with occupancy 5 and overrun set.
        for (int i = 0; i < 9; i++) strobe(8'h60 + 8'(i));
        m_ack = 1'b1;
        repeat (3) tick();
        m_ack = 1'b0;
        check("pre_rst_count", {28'd0, count}, 32'd5);
        check("pre_rst_ovr", {31'd0, overrun}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_count", {28'd0, count}, 32'd0);
        check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
        check("mid_rst_tmo", {31'd0, timeout}, 32'd0);
        check("mid_rst_data", {24'd0, m_data}, 32'd0);
        strobe(8'h7E);
        check("post_rst_valid", {31'd0, m_valid}, 32'd1);
        check("post_rst_head", {24'd0, m_data}, 32'h7E);
        drain();
        check("final_count", {28'd0, count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
